// File: rtl/sixteen_bit_serial_incrementer.sv
// Bit-serial 16-bit incrementer: b = a + 1, one bit per clock through a
// single half-adder cell and a carry flop.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   a     - 16-bit operand, captured on the accepting edge
//   busy  - high while an operation is in progress
//   done  - one-cycle pulse, b valid with it
//   b     - {carry_out, sum[15:0]}, held until the next completion
module sixteen_bit_serial_incrementer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    output logic        busy,
    output logic        done,
    output logic [16:0] b
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [15:0] res_q, res_d;
    logic        cy_q, cy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] b_q, b_d;

    // Half-adder cell: sum and carry for the current bit.
    logic s;
    logic c;

    assign s = sr_q[0] ^ cy_q;
    assign c = sr_q[0] & cy_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        res_d   = res_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = a;
                    // The +1 enters as the initial carry.
                    cy_d    = 1'b1;
                    cnt_d   = 4'd0;
                    res_d   = 16'h0000;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cy_d  = c;
                sr_d  = {1'b0, sr_q[15:1]};
                res_d = {s, res_q[15:1]};
                cnt_d = cnt_q + 4'd1;
                // Fixed latency: always run all 16 bits.
                if (cnt_q == 4'd15) begin
                    b_d     = {c, s, res_q[15:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= 16'h0000;
            res_q   <= 16'h0000;
            cy_q    <= 1'b0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            b_q     <= 17'h00000;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            b_q     <= b_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign b    = b_q;

endmodule

// File: tb/tb_sixteen_bit_serial_incrementer.sv
// Scoreboard bench for sixteen_bit_serial_incrementer.
// Expected sums are queued at stimulus time and popped on each done.
module tb_sixteen_bit_serial_incrementer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic        busy;
    logic        done;
    logic [16:0] b;

    int tests;
    int fails;
    int cyc;
    logic [16:0] sb[$];

    sixteen_bit_serial_incrementer dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .busy (busy),
        .done (done),
        .b    (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Output monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_in_done", 32'(busy), 32'd0);
            if (sb.size() == 0)
                chk("spurious_done", 32'd1, 32'd0);
            else
                chk("b", 32'(b), 32'(sb.pop_front()));
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [15:0] v, input bit xchk);
        int k;
        @(negedge clk);
        a     = v;
        start = 1'b1;
        sb.push_back(17'(v) + 17'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(k);
        chk("latency", 32'(k), 32'd16);
        if (xchk && v != 16'h0000)
            chk("dec_xchk", 32'(b[15:0]), 32'(16'(v - 16'd1 + 16'd2)));
    endtask

    initial begin
        int k;
        int d1;
        int d2;
        logic [15:0] v;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        rst = 1'b0;

        op(16'h0000, 1'b0);
        op(16'hFFFF, 1'b0);
        op(16'h00FF, 1'b0);
        op(16'h7FFF, 1'b0);
        op(16'h1234, 1'b0);
        for (int i = 0; i < 24; i++) begin
            v = 16'($urandom);
            op(v, 1'b1);
        end

        // Back-to-back with start held high.
        @(negedge clk);
        a     = 16'h0001;
        start = 1'b1;
        sb.push_back(17'h00002);
        @(negedge clk);
        a = 16'h0002;
        wait_done(k);
        d1 = cyc;
        sb.push_back(17'h00003);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", 32'(busy), 32'd1);
        wait_done(k);
        d2 = cyc;
        chk("b2b_spacing", 32'(d2 - d1), 32'd17);

        // Start and operand change during BUSY are ignored.
        @(negedge clk);
        a     = 16'h0010;
        start = 1'b1;
        sb.push_back(17'h00011);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a     = 16'hAAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        repeat (25) @(negedge clk);
        chk("ignore_hold_b", 32'(b), 32'h00011);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a     = 16'h4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_b", 32'(b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("arst_no_done_b", 32'(b), 32'd0);
        op(16'h0005, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sixteen_bit_serial_incrementer.md
# sixteen_bit_serial_incrementer

Bit-serial 16-bit incrementer, the up-direction counterpart to the team's ripple decrementer. It computes b = a + 1 one bit per clock using a single half-adder cell and a carry flip-flop. The 17-bit result carries the carry-out in b[16], matching the decrementer's 17-bit output format (b[16] = borrow there). It sits beside the decrementer in the arithmetic datapath where area matters more than latency.

## Interface
- No parameters; width fixed at 16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when idle.
- a  input  16  operand; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; b is valid with it.
- b  output  17  result {carry_out, sum[15:0]}; held until the next completion.

## Operation
- State: FSM {IDLE, BUSY}, 16-bit operand shift register sr, 16-bit result shift register res, carry flip-flop cy, 4-bit bit counter cnt.
- IDLE, start=1: sr<=a, cy<=1 (the +1 injected as initial carry), cnt<=0, res<=0, busy<=1, go to BUSY.
- IDLE, start=0: hold; done<=0.
- Each BUSY cycle processes bit cnt:
  - s = sr[0] XOR cy; cy<=sr[0] AND cy.
  - sr shifts right; s enters res at bit 15, so res shifts right.
  - cnt<=cnt+1.
- On the BUSY cycle with cnt=15:
  - b<={sr[0]&cy, s, res[15:1]}.
  - done<=1, busy<=0, go to IDLE.
- Fixed latency, with no early exit when the carry dies out.
- start while BUSY is ignored. It is not queued, and a changing during BUSY has no effect.
- b changes only at completion and is not cleared by start.
- Arithmetic: b = a + 1 as a 17-bit unsigned sum. b[16]=1 only for a=0xFFFF.

## Timing
- Reset, asynchronous, any time: state=IDLE, busy=0, done=0, b=17'h0, sr=res=0, cy=0, cnt=0.
- Reset mid-operation aborts the operation. No done pulse and b stays 0.
- First start after reset release is accepted on the first rising edge with start=1.
- Accept at edge E0: busy=1 after E0.
- Bits 0..15 are processed on edges E1..E16.
- After E16: done=1, busy=0, b valid. Latency is 16 cycles from the accepting edge to done.
- done is high for exactly one cycle, the first IDLE cycle.
- A start present in that done cycle is accepted at edge E16+1, giving back-to-back throughput of one result per 17 cycles.
- busy and done are never both high.

## Test plan
- Reset, then start with a=16'h0000 -> done 16 cycles after accept, b=17'h00001, busy low in the done cycle.
- a=16'hFFFF -> b=17'h10000 (carry-out set). Then a=16'h00FF -> b=17'h00100.
- a=16'h7FFF -> b=17'h08000. a=16'h1234 -> b=17'h01235. Exhaustive or random sweep against the a+1 model, with the decrementer result +2 as a cross-check where a≥1.
- Back-to-back: start held high with a=16'h0001 then a=16'h0002 -> two done pulses 17 cycles apart, b=17'h00002 then 17'h00003.
- start pulsed and a changed to 16'hAAAA at cycle 5 of an operation on a=16'h0010 -> ignored, result b=17'h00011, single done pulse.
- rst asserted asynchronously at cycle 8 of an operation -> busy=0, done=0, b=0 immediately. No done pulse follows. A fresh start with a=16'h0005 then gives b=17'h00006.
